imm_gen_stage: RTL
==================

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter: XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter: AUTO_DECODE, default 1; 1 = format derived from opcode, 0 = format taken from in_sel.
REQ-003 Parameter: CNT_W, default 16, width of the illegal-format counter.
REQ-004 Port: clk  input  1  single rising-edge clock for all state.
REQ-005 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port: in_valid  input  1  upstream instruction valid.
REQ-007 Port: in_ready  output  1  stage can accept an instruction.
REQ-008 Port: in_instr  input  32  raw instruction word.
REQ-009 Port: in_sel  input  3  explicit format select; used only when AUTO_DECODE=0.
REQ-010 Port: out_valid  output  1  immediate result valid.
REQ-011 Port: out_ready  input  1  downstream accepts result.
REQ-012 Port: out_imm  output  XLEN  extended immediate.
REQ-013 Port: out_fmt  output  3  format code applied.
REQ-014 Port: out_illegal  output  1  no immediate format matched.
REQ-015 Port: illegal_cnt  output  CNT_W  saturating count of illegal results accepted by downstream.

Function
REQ-016 Format codes SHALL be: 000 none, 001 U, 010 I, 011 shamt, 100 B, 101 S, 110 J, 111 CSR-zimm.
REQ-017 U: imm[31:12]=instr[31:12], imm[11:0]=0, bits above 31 = instr[31].
REQ-018 I: imm[11:0]=instr[31:20], sign-filled from instr[31] up to XLEN-1.
REQ-019 shamt: XLEN=32 -> imm[4:0]=instr[24:20]; XLEN=64 -> imm[5:0]=instr[25:20]; all higher bits 0.
REQ-020 B: imm[0]=0, [4:1]=instr[11:8], [10:5]=instr[30:25], [11]=instr[7], [12] and above = instr[31] to XLEN-1.
REQ-021 S: imm[4:0]=instr[11:7], [11:5]=instr[31:25], sign-filled from instr[31].
REQ-022 J: imm[0]=0, [10:1]=instr[30:21], [11]=instr[20], [19:12]=instr[19:12], [20] and above = instr[31].
REQ-023 CSR-zimm: imm[4:0]=instr[19:15], higher bits 0.
REQ-024 Auto decode (instr[6:0]): 0110111/0010111 -> U; 1101111 -> J; 1100111, 0000011 -> I; 0010011 -> shamt if funct3 in {001,101}, else I; 0011011 -> same as 0010011 when XLEN=64, otherwise illegal; 1100011 -> B; 0100011 -> S; 1110011 -> CSR-zimm if instr[14]=1, else I.
REQ-025 Any other opcode (auto), or in_sel=000 (manual), SHALL yield out_fmt=000, out_imm=0, out_illegal=1.
REQ-026 The stage SHALL be a 2-entry FIFO (skid buffer); a transfer occurs when valid and ready are both high on a rising edge.
REQ-027 Latency: an accepted instruction SHALL appear on out_* on the cycle after acceptance when the buffer was empty.
REQ-028 in_ready SHALL be a registered signal: high when occupancy < 2, with no combinational path from out_ready.
REQ-029 Simultaneous push and pop at occupancy 1 SHALL keep occupancy at 1 and preserve order.
REQ-030 When occupancy is 2, in_valid SHALL be ignored; no entry is overwritten.
REQ-031 out_valid=1 with out_ready=0 SHALL hold out_imm, out_fmt and out_illegal stable.
REQ-032 illegal_cnt SHALL increment on each output transfer with out_illegal=1 and saturate at all-ones.
REQ-033 Extraction SHALL be combinational on the input side; results are stored in the buffer, not recomputed at the output.

Reset
REQ-034 On a clock edge with rst_n=0: occupancy=0, out_valid=0, in_ready=0, out_imm=0, out_fmt=000, out_illegal=0, illegal_cnt=0.
REQ-035 in_ready SHALL rise on the first edge after rst_n returns high.
REQ-036 Reset asserted mid-operation SHALL discard buffered entries; no partial transfer is emitted.

Structure
REQ-037 Format codes, opcode constants and the funct3 shift values SHALL live in a shared package imm_pkg.
REQ-038 Per-format bit extraction SHALL be one combinational sub-module imm_fmt_extract(instr, fmt, XLEN) -> imm; imm_gen_stage instantiates it once.

Verification
REQ-039 XLEN=32, auto decode, in=0xFE000EE3 (BEQ, offset -4), out_ready=1 -> next cycle out_fmt=100, out_imm=0xFFFFFFFC.
REQ-040 XLEN=64, auto decode, in=0x03F09093 (SLLI shamt 63) -> out_fmt=011, out_imm=0x000000000000003F; in=0x800000EF (JAL) -> out_imm=0xFFFFFFFFFFF00000.
REQ-041 out_ready=0, push 3 instructions back-to-back -> in_ready low after the 2nd accept; the 3rd is held upstream; releasing out_ready -> all 3 emerge in order.
REQ-042 AUTO_DECODE=0, in_sel=000 then opcode 0x0000007F in auto mode -> out_illegal=1, out_imm=0; illegal_cnt increments per accepted output; preloaded count of 0xFFFF stays at 0xFFFF.
REQ-043 rst_n low for 1 cycle with 2 entries buffered -> out_valid=0 and illegal_cnt=0 after the edge; in_ready=1 one edge after release.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg
// Shared definitions for the immediate-generation stage:
//   - imm_fmt_e : 3-bit immediate format code carried with every result
//   - OP_*      : major opcodes (instr[6:0]) recognised by the auto decoder
//   - F3_*      : funct3 values that turn an OP-IMM into a shift
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'b000,
        FMT_U     = 3'b001,
        FMT_I     = 3'b010,
        FMT_SHAMT = 3'b011,
        FMT_B     = 3'b100,
        FMT_S     = 3'b101,
        FMT_J     = 3'b110,
        FMT_CSR   = 3'b111
    } imm_fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/imm_fmt_extract.sv
// imm_fmt_extract
// Purely combinational per-format immediate extraction.
// Ports:
//   instr : raw 32-bit instruction word
//   fmt   : format to apply (FMT_NONE yields zero)
//   imm   : XLEN-bit extended immediate
module imm_fmt_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    // The opcode field never contributes to an immediate.
    logic w_unused_opcode;
    assign w_unused_opcode = ^instr[6:0];

    // Every signed format is first assembled as a 32-bit value and then
    // widened; a size cast of a signed operand sign-extends to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    always_comb begin
        imm = '0;
        unique case (fmt)
            FMT_U:     imm = sext32({instr[31:12], 12'b0});
            FMT_I:     imm = sext32({{20{instr[31]}}, instr[31:20]});
            FMT_SHAMT: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
            FMT_B:     imm = sext32({{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0});
            FMT_S:     imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
            FMT_J:     imm = sext32({{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0});
            FMT_CSR:   imm = XLEN'(instr[19:15]);
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage
// Decodes the immediate format of an instruction, extracts the extended
// immediate on the input side and stores the result in a 2-entry skid FIFO.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   in_valid/in_ready       : upstream handshake (in_ready is registered)
//   in_instr, in_sel        : instruction word, manual format (AUTO_DECODE=0)
//   out_valid/out_ready     : downstream handshake
//   out_imm, out_fmt        : extended immediate and applied format code
//   out_illegal             : no format matched
//   illegal_cnt             : saturating count of illegal results delivered
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    function automatic imm_fmt_e auto_fmt(input logic [31:0] instr);
        imm_fmt_e f;
        logic     is_shift;
        is_shift = (instr[14:12] == F3_SLL) || (instr[14:12] == F3_SRX);
        f = FMT_NONE;
        case (instr[6:0])
            OP_LUI, OP_AUIPC:  f = FMT_U;
            OP_JAL:            f = FMT_J;
            OP_JALR, OP_LOAD:  f = FMT_I;
            OP_IMM:            f = is_shift ? FMT_SHAMT : FMT_I;
            // The word-sized immediate ops only exist on a 64-bit machine.
            OP_IMM32:          f = (XLEN == 64) ? (is_shift ? FMT_SHAMT : FMT_I) : FMT_NONE;
            OP_BRANCH:         f = FMT_B;
            OP_STORE:          f = FMT_S;
            OP_SYSTEM:         f = instr[14] ? FMT_CSR : FMT_I;
            default:           f = FMT_NONE;
        endcase
        return f;
    endfunction

    imm_fmt_e        w_fmt;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;

    always_comb begin
        w_fmt     = (AUTO_DECODE != 0) ? auto_fmt(in_instr) : imm_fmt_e'(in_sel);
        w_illegal = (w_fmt == FMT_NONE);
    end

    imm_fmt_extract #(.XLEN(XLEN)) u_extract (
        .instr (in_instr),
        .fmt   (w_fmt),
        .imm   (w_imm)
    );

    // Two-entry circular buffer holding fully extracted results.
    logic [XLEN-1:0]  r_imm [2];
    logic [2:0]       r_fmt [2];
    logic             r_ill [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_illegal_cnt;

    logic       w_push;
    logic       w_pop;
    logic [1:0] w_count_nxt;

    assign out_valid   = (r_count != 2'd0);
    assign in_ready    = r_in_ready;
    assign w_push      = in_valid && r_in_ready;
    assign w_pop       = out_valid && out_ready;
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    assign out_imm     = r_imm[r_rd_ptr];
    assign out_fmt     = r_fmt[r_rd_ptr];
    assign out_illegal = r_ill[r_rd_ptr];
    assign illegal_cnt = r_illegal_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_in_ready    <= 1'b0;
            r_illegal_cnt <= '0;
            for (int i = 0; i < 2; i++) begin
                r_imm[i] <= '0;
                r_fmt[i] <= FMT_NONE;
                r_ill[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_imm[r_wr_ptr] <= w_imm;
                r_fmt[r_wr_ptr] <= w_fmt;
                r_ill[r_wr_ptr] <= w_illegal;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count    <= w_count_nxt;
            // Ready is computed from next occupancy so it never depends
            // combinationally on out_ready.
            r_in_ready <= (w_count_nxt < 2'd2);
            if (w_pop && r_ill[r_rd_ptr] && (r_illegal_cnt != {CNT_W{1'b1}})) begin
                r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
            end
        end
    end

endmodule
